// File: rtl/aud_sram_ctrl.sv
// Voice-path sequencer: key decode, recorder/player control pulses, SRAM ownership.
// Define AUD_CTRL_LOOP_EN to loop playback from address 0 instead of stopping at the end.
module aud_sram_ctrl #(
    parameter int                ADDR_W   = 20,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_data,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic [2:0]        o_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REC    = 3'd1;
    localparam logic [2:0] S_REC_P  = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_PLAY_P = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] last_addr_q, end_addr_q, addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_n_q, loop_q, loop_d;
    logic              k_stop, k_pause, k_play, k_rec;
    logic              rs_d, rp_d, rt_d, ps_d, pp_d, pt_d, clr_d;
    logic              in_play, wr_det, auto_stop, play_end;

    always_comb begin
        k_stop  = 1'b0;
        k_pause = 1'b0;
        k_play  = 1'b0;
        k_rec   = 1'b0;
        priority case (1'b1)
            i_key_stop:  k_stop  = 1'b1;
            i_key_pause: k_pause = 1'b1;
            i_key_play:  k_play  = 1'b1;
            i_key_rec:   k_rec   = 1'b1;
            default:     ;
        endcase
    end

    assign in_play   = (state_q == S_PLAY) || (state_q == S_PLAY_P);
    // Only one write per detected sample; the write cycle itself masks detection.
    assign wr_det    = (state_q == S_REC) && we_n_q && (i_rec_addr != last_addr_q);
    assign auto_stop = !we_n_q && (addr_q == ADDR_MAX)
                     && ((state_q == S_REC) || (state_q == S_REC_P));
    assign play_end  = (state_q == S_PLAY) && (i_play_addr > end_addr_q)
                     && !loop_q && !o_play_stop && !o_play_start;

    always_comb begin
        state_d = state_q;
        rs_d = 1'b0; rp_d = 1'b0; rt_d = 1'b0;
        ps_d = 1'b0; pp_d = 1'b0; pt_d = 1'b0;
        clr_d  = 1'b0;
        loop_d = 1'b0;
        if (auto_stop) begin
            state_d = S_IDLE;
            rt_d    = 1'b1;
        end else if (play_end) begin
            pt_d = 1'b1;
`ifdef AUD_CTRL_LOOP_EN
            loop_d  = 1'b1;
`else
            state_d = S_IDLE;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (k_rec) begin
                        state_d = S_REC;
                        rs_d    = 1'b1;
                        clr_d   = 1'b1;
                    end else if (k_play && (end_addr_q != '0)) begin
                        state_d = S_PLAY;
                        ps_d    = 1'b1;
                    end
                end
                S_REC: begin
                    if (k_stop) begin
                        state_d = S_IDLE;
                        rt_d    = 1'b1;
                    end else if (k_pause) begin
                        state_d = S_REC_P;
                        rp_d    = 1'b1;
                    end
                end
                S_REC_P: begin
                    if (k_stop) begin
                        state_d = S_IDLE;
                        rt_d    = 1'b1;
                    end else if (k_rec) begin
                        state_d = S_REC;
                        rs_d    = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (k_stop) begin
                        state_d = S_IDLE;
                        pt_d    = 1'b1;
                    end else if (loop_q) begin
                        ps_d = 1'b1;
                    end else if (k_pause) begin
                        state_d = S_PLAY_P;
                        pp_d    = 1'b1;
                    end
                end
                S_PLAY_P: begin
                    if (k_stop) begin
                        state_d = S_IDLE;
                        pt_d    = 1'b1;
                    end else if (k_play) begin
                        state_d = S_PLAY;
                        ps_d    = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            loop_q       <= 1'b0;
            o_rec_start  <= 1'b0;
            o_rec_pause  <= 1'b0;
            o_rec_stop   <= 1'b0;
            o_play_start <= 1'b0;
            o_play_pause <= 1'b0;
            o_play_stop  <= 1'b0;
        end else begin
            state_q      <= state_d;
            loop_q       <= loop_d;
            o_rec_start  <= rs_d;
            o_rec_pause  <= rp_d;
            o_rec_stop   <= rt_d;
            o_play_start <= ps_d;
            o_play_pause <= pp_d;
            o_play_stop  <= pt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_addr_q <= '0;
            end_addr_q  <= '0;
        end else begin
            we_n_q <= !wr_det;
            if (wr_det) begin
                addr_q      <= last_addr_q;
                wdata_q     <= i_rec_data;
                last_addr_q <= i_rec_addr;
                end_addr_q  <= last_addr_q;
            end else if (in_play) begin
                addr_q <= i_play_addr;
            end
            if (clr_d) begin
                last_addr_q <= '0;
                end_addr_q  <= '0;
            end
            if (auto_stop) begin
                end_addr_q <= ADDR_MAX;
            end
        end
    end

    assign o_sram_addr  = in_play ? i_play_addr : addr_q;
    assign o_sram_oe_n  = !in_play;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_wdata = wdata_q;
    assign o_end_addr   = end_addr_q;
    assign o_state      = state_q;

endmodule
